data_ram_responder: RTL and testbench
=====================================

// Module: data_ram_responder
// PURPOSE
// - Responder end of the CPU data-memory port driven by stage_memory.
// - Inputs: ram_address, ram_write_enable, ram_write_data. Output: ram_data.
// - Word-addressed data RAM in the lower half of the address space.
// - MMIO window in the upper half: console TX FIFO with valid/ready drain port, status register, free-running cycle counter.
// PARAMETERS
// - ADDR_WIDTH  10  width of ram_address. MSB=0 selects RAM (2**(ADDR_WIDTH-1) words); MSB=1 selects MMIO.
// - FIFO_DEPTH  4   console TX FIFO entries. Power of two, 2..16.
// PORTS
// - clk               in   1           system clock, all state updates on posedge
// - reset             in   1           asynchronous, active-high
// - ram_address       in   ADDR_WIDTH  word address from the MEM stage
// - ram_write_enable  in   1           write strobe, sampled at posedge clk
// - ram_write_data    in   32          write data (Word)
// - ram_data          out  32          read data (Word), combinational from ram_address
// - tx_valid          out  1           console FIFO not empty
// - tx_data           out  8           FIFO head byte
// - tx_ready          in   1           consumer accepts head; pop on tx_valid && tx_ready at posedge
// BEHAVIOUR
// - Reset (async, active-high):
//   - FIFO emptied; overflow flag cleared; cycle counter = 0.
//   - tx_valid=0, tx_data=0, ram_data=0 while reset is high.
//   - RAM array is not cleared.
// - Read latency 0:
//   - ram_data is combinational on ram_address and current state.
//   - The MEM stage consumes it in the same cycle.
// - Write latency 1:
//   - Takes effect at the posedge where ram_write_enable=1.
//   - Same-cycle read of the written address returns the OLD value.
// - RAM: MSB=0 -> word index ram_address[ADDR_WIDTH-2:0]. 32-bit write, no byte enables.
// - MMIO: MSB=1, offset = ram_address[1:0]. Higher offset bits ignored (aliasing).
//   - off 0 CONSOLE_TX:
//     - Write pushes ram_write_data[7:0].
//     - If full and no pop this cycle: write dropped, overflow flag set (sticky).
//     - Reads 0.
//   - off 1 STATUS read: [0]=full, [1]=empty, [2]=overflow, [7:4]=count, others 0.
//     - Write with bit2=1 clears overflow; other bits ignored.
//     - Clear and new overflow in the same cycle -> overflow stays set.
//   - off 2 CYCLES: read returns current counter; write loads ram_write_data.
//   - off 3: reads 0, writes ignored.
// - Cycle counter:
//   - +1 every posedge out of reset.
//   - Wraps 0xFFFFFFFF -> 0.
//   - A write load takes priority over the increment (next value = written value).
// - FIFO:
//   - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
//   - tx_data = head entry while tx_valid; 0 when empty.
//   - Simultaneous push and pop:
//     - Both occur, count unchanged.
//     - Allowed when full; pop frees the slot.
//     - When empty, no pop exists (tx_valid=0); push proceeds.
//   - tx_ready while empty: no effect.
// - STATUS reads and tx_valid reflect pre-edge state (no bypass).
// - Reset asserted mid-operation: FIFO contents and pending write discarded immediately.
// CONFIGURATION
// - RAM_CYCLE_COUNTER_EN defined: cycle counter present as above.
// - RAM_CYCLE_COUNTER_EN undefined: no counter register. Offset 2 reads 0, writes ignored.
// TESTING
// 1. RAM write/read-back:
//    - Write 0xDEADBEEF @0x005, then read @0x005 -> 0xDEADBEEF.
//    - Same-cycle read during the write -> prior value.
// 2. FIFO fill/drain:
//    - tx_ready=0; push 'A','B','C','D' -> STATUS=0x41 (count 4, full).
//    - 5th push 'E' -> dropped, STATUS bit2=1.
//    - Raise tx_ready -> tx_data 'A','B','C','D' on 4 consecutive cycles, then tx_valid=0, STATUS=0x06.
// 3. Full + simultaneous push/pop:
//    - FIFO full, tx_ready=1, push 'Z' -> count stays 4, overflow stays 0.
//    - 'Z' emerges 4th after the current head.
// 4. Overflow clear:
//    - Write STATUS 0x4 -> bit2 reads 0 next cycle.
//    - Clear coincident with a dropped push -> bit2 remains 1.
// 5. Cycle counter (RAM_CYCLE_COUNTER_EN):
//    - Write 0xFFFFFFFE -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x0 on successive cycles.
//    - Without macro: reads 0.
// 6. Async reset mid-drain (FIFO holding 3 entries):
//    - Assert reset between edges -> tx_valid=0 and ram_data=0 immediately.
//    - After release: STATUS=0x02, RAM data preserved.

Source files
------------

// File: rtl/data_ram_responder.sv
// data_ram_responder: responder end of the CPU data-memory port.
// Lower half of the word address space is a plain 32-bit data RAM.
// Upper half is an MMIO window (offset = ram_address[1:0], higher bits alias):
//   0 CONSOLE_TX  write pushes a byte into the console FIFO, reads 0
//   1 STATUS      [0]=full [1]=empty [2]=overflow [7:4]=count; write bit2 clears overflow
//   2 CYCLES      free-running cycle counter, write loads it
//   3             reads 0, writes ignored
// Optional feature macro: RAM_CYCLE_COUNTER_EN (counter present when defined,
// otherwise offset 2 reads 0 and writes are ignored).
module data_ram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ram_address,
    input  logic                  ram_write_enable,
    input  logic [31:0]           ram_write_data,
    output logic [31:0]           ram_data,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready
);

    localparam int RAM_WORDS = 2 ** (ADDR_WIDTH - 1);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    logic [31:0]           mem_q [RAM_WORDS];
    logic [7:0]            fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic                  isMmio;
    logic [1:0]            mmioOffset;
    logic [ADDR_WIDTH-2:0] ramIndex;
    logic                  fifoFull, fifoEmpty;
    logic                  popFire, txWrite, pushFire, pushDrop, statusClear;
    logic                  ramWrite;
    logic [31:0]           statusWord;
    logic [31:0]           cyclesRead;
    logic [31:0]           readMux;

    assign isMmio     = ram_address[ADDR_WIDTH-1];
    assign mmioOffset = ram_address[1:0];
    assign ramIndex   = ram_address[ADDR_WIDTH-2:0];

    assign fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty = (count_q == '0);

    // A pop only exists when there is something to hand out; a full FIFO can
    // still accept a push in the same cycle because the pop frees a slot.
    assign popFire     = !fifoEmpty && tx_ready;
    assign txWrite     = ram_write_enable && isMmio && (mmioOffset == 2'd0);
    assign pushFire    = txWrite && (!fifoFull || popFire);
    assign pushDrop    = txWrite && fifoFull && !popFire;
    assign statusClear = ram_write_enable && isMmio && (mmioOffset == 2'd1) && ram_write_data[2];
    assign ramWrite    = ram_write_enable && !isMmio && !reset;

    // Count is shown in a 4-bit field; with a 16-deep FIFO a full count wraps to 0 there, and the full bit disambiguates.
    assign statusWord = {24'd0, 4'(count_q), 1'b0, overflow_q, fifoEmpty, fifoFull};

    // Next-state for FIFO pointers, occupancy and the sticky overflow flag (a new drop wins over a clear).
    always_comb begin
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (popFire) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (pushFire) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        case ({pushFire, popFire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (pushDrop) begin
            overflow_d = 1'b1;
        end else if (statusClear) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO control state; reset empties the FIFO and drops the overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage arrays carry no reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (ramWrite) begin
            mem_q[ramIndex] <= ram_write_data;
        end
        if (pushFire && !reset) begin
            fifo_q[wrPtr_q] <= ram_write_data[7:0];
        end
    end

`ifdef RAM_CYCLE_COUNTER_EN
    logic [31:0] cycles_q;
    logic        cyclesWrite;

    assign cyclesWrite = ram_write_enable && isMmio && (mmioOffset == 2'd2);
    assign cyclesRead  = cycles_q;

    // Free-running cycle counter; a software load replaces that cycle's increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
        end else if (cyclesWrite) begin
            cycles_q <= ram_write_data;
        end else begin
            cycles_q <= cycles_q + 32'd1;
        end
    end
`else
    assign cyclesRead = '0;
`endif

    // Zero-latency read path: the MEM stage consumes this in the same cycle, so it shows pre-edge state.
    always_comb begin
        readMux = '0;
        if (!isMmio) begin
            readMux = mem_q[ramIndex];
        end else begin
            case (mmioOffset)
                2'd1:    readMux = statusWord;
                2'd2:    readMux = cyclesRead;
                default: readMux = '0;
            endcase
        end
    end

    assign ram_data = reset ? 32'd0 : readMux;
    assign tx_valid = !reset && !fifoEmpty;
    assign tx_data  = (reset || fifoEmpty) ? 8'd0 : fifo_q[rdPtr_q];

endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: directed bench for data_ram_responder with a queue
// scoreboard for console bytes. Counter expectations follow RAM_CYCLE_COUNTER_EN.
module tb_data_ram_responder;

    localparam int ADDR_WIDTH = 10;
    localparam int FIFO_DEPTH = 4;

    localparam logic [9:0] A_TX     = 10'h200;
    localparam logic [9:0] A_STATUS = 10'h201;
    localparam logic [9:0] A_CYCLES = 10'h202;
    localparam logic [9:0] A_OFF3   = 10'h203;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  ram_address = '0;
    logic        ram_write_enable = 1'b0;
    logic [31:0] ram_write_data = '0;
    logic [31:0] ram_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] txExp [$];

    data_ram_responder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ram_address(ram_address),
        .ram_write_enable(ram_write_enable),
        .ram_write_data(ram_write_data),
        .ram_data(ram_data),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // One comparison: count it, and report tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check the console port against the scoreboard
    // before the edge, update the scoreboard, then advance to just past the edge.
    task automatic applyStimulus(input logic [9:0] addr, input logic we, input logic [31:0] wd, input logic rdy);
        logic [7:0] head;
        ram_address      = addr;
        ram_write_enable = we;
        ram_write_data   = wd;
        tx_ready         = rdy;
        #1;
        checkOutput("tx_valid", {31'd0, tx_valid}, {31'd0, txExp.size() != 0});
        if (txExp.size() != 0 && rdy) begin
            head = txExp.pop_front();
            checkOutput("tx_data", {24'd0, tx_data}, {24'd0, head});
        end
        if (we && addr == A_TX && txExp.size() < FIFO_DEPTH) begin
            txExp.push_back(wd[7:0]);
        end
        @(posedge clk);
        #1;
        ram_write_enable = 1'b0;
    endtask

    // Combinational read check that does not advance the clock.
    task automatic readCheck(input string tag, input logic [9:0] addr, input logic [31:0] expected);
        ram_address      = addr;
        ram_write_enable = 1'b0;
        #1;
        checkOutput(tag, ram_data, expected);
    endtask

    task automatic idleDrain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(10'h000, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic fillFour(input logic [7:0] base);
        for (int i = 0; i < 4; i++) applyStimulus(A_TX, 1'b1, {24'd0, base + 8'(i)}, 1'b0);
    endtask

    initial begin
        $display("[TB] start");

        // Reset state
        #12;
        readCheck("reset_ram_data", A_STATUS, 32'h0);
        checkOutput("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("reset_tx_data", {24'd0, tx_data}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        readCheck("status_after_reset", A_STATUS, 32'h02);
        readCheck("off3_read", A_OFF3, 32'h0);

        // RAM write / read-back, including same-cycle old value
        applyStimulus(10'h005, 1'b1, 32'h11111111, 1'b0);
        readCheck("ram_first_write", 10'h005, 32'h11111111);
        ram_address = 10'h005; ram_write_enable = 1'b1; ram_write_data = 32'hDEADBEEF;
        #1;
        checkOutput("ram_same_cycle_old", ram_data, 32'h11111111);
        @(posedge clk);
        #1;
        ram_write_enable = 1'b0;
        readCheck("ram_readback", 10'h005, 32'hDEADBEEF);
        applyStimulus(10'h006, 1'b1, 32'h12345678, 1'b0);
        readCheck("ram_neighbor_untouched", 10'h005, 32'hDEADBEEF);
        readCheck("ram_neighbor", 10'h006, 32'h12345678);

        // FIFO fill, overflow on fifth push, drain
        fillFour(8'h41);
        readCheck("status_full", A_STATUS, 32'h41);
        applyStimulus(A_TX, 1'b1, 32'h45, 1'b0);
        readCheck("status_overflow", A_STATUS, 32'h45);
        readCheck("status_alias", 10'h205, 32'h45);
        readCheck("tx_read_zero", A_TX, 32'h0);
        idleDrain(4);
        checkOutput("drained_valid", {31'd0, tx_valid}, 32'd0);
        readCheck("status_drained", A_STATUS, 32'h06);
        applyStimulus(A_STATUS, 1'b1, 32'h4, 1'b0);
        readCheck("status_cleared", A_STATUS, 32'h02);

        // Full FIFO with simultaneous push and pop
        fillFour(8'h50);
        applyStimulus(A_TX, 1'b1, 32'h5A, 1'b1);
        readCheck("status_push_pop_full", A_STATUS, 32'h41);
        idleDrain(4);
        readCheck("status_after_z", A_STATUS, 32'h02);

        // Overflow clear only on bit2
        fillFour(8'h61);
        applyStimulus(A_TX, 1'b1, 32'h65, 1'b0);
        applyStimulus(A_STATUS, 1'b1, 32'hFFFF_FFFB, 1'b0);
        readCheck("status_no_clear", A_STATUS, 32'h45);
        applyStimulus(A_STATUS, 1'b1, 32'h4, 1'b0);
        readCheck("status_clear_full", A_STATUS, 32'h41);
        idleDrain(4);

        // Cycle counter load and wrap
        applyStimulus(A_CYCLES, 1'b1, 32'hFFFF_FFFE, 1'b0);
`ifdef RAM_CYCLE_COUNTER_EN
        readCheck("cycles_load", A_CYCLES, 32'hFFFF_FFFE);
        applyStimulus(10'h000, 1'b0, 32'd0, 1'b0);
        readCheck("cycles_max", A_CYCLES, 32'hFFFF_FFFF);
        applyStimulus(10'h000, 1'b0, 32'd0, 1'b0);
        readCheck("cycles_wrap", A_CYCLES, 32'h0);
`else
        readCheck("cycles_absent_a", A_CYCLES, 32'h0);
        applyStimulus(10'h000, 1'b0, 32'd0, 1'b0);
        readCheck("cycles_absent_b", A_CYCLES, 32'h0);
`endif

        // Async reset while the FIFO holds three entries
        fillFour(8'h71);
        applyStimulus(10'h000, 1'b0, 32'd0, 1'b1);
        ram_address = 10'h005; ram_write_enable = 1'b0; tx_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("midreset_ram_data", ram_data, 32'h0);
        checkOutput("midreset_tx_data", {24'd0, tx_data}, 32'd0);
        txExp.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        tx_ready = 1'b0;
        readCheck("status_post_reset", A_STATUS, 32'h02);
        readCheck("cycles_post_reset", A_CYCLES, 32'h0);
        readCheck("ram_preserved_5", 10'h005, 32'hDEADBEEF);
        readCheck("ram_preserved_6", 10'h006, 32'h12345678);
        applyStimulus(10'h000, 1'b0, 32'd0, 1'b0);
`ifdef RAM_CYCLE_COUNTER_EN
        readCheck("cycles_first_tick", A_CYCLES, 32'h1);
`else
        readCheck("cycles_first_tick", A_CYCLES, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
